// File: rtl/food_spawner.sv
// food_spawner
//   Producer side of the snake food interface. Owns NUM_FOOD food slots,
//   detects the snake head landing on a placed slot, retires that slot one
//   cycle later (so each hit is counted once) and refills empty slots at
//   pseudo-random free grid cells drawn from a 16-bit LFSR.
//
// Ports
//   clk         system clock
//   reset       synchronous, active-high reset
//   headx       snake head x, pixels
//   heady       snake head y, pixels
//   foodx       per-slot x, pixels (10'h3FF while the slot is empty)
//   foody       per-slot y, pixels (9'h1FF while the slot is empty)
//   food_valid  bit i set when slot i holds placed food
//   eaten       one-cycle pulse: a slot was eaten
//   eaten_idx   index of the eaten slot, meaningful while eaten=1
//   all_placed  1 while every slot holds food
module food_spawner #(
    parameter int          NUM_FOOD = 9,
    parameter int          CELL     = 10,
    parameter int          COLS     = 64,
    parameter int          ROWS     = 48,
    parameter logic [15:0] SEED     = 16'hACE1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [9:0]          headx,
    input  logic [8:0]          heady,
    output logic [9:0]          foodx [NUM_FOOD],
    output logic [8:0]          foody [NUM_FOOD],
    output logic [NUM_FOOD-1:0] food_valid,
    output logic                eaten,
    output logic [3:0]          eaten_idx,
    output logic                all_placed
);

    // Off-grid parking values: no legal head position can ever equal them.
    localparam logic [9:0] PARK_X = 10'h3FF;
    localparam logic [8:0] PARK_Y = 9'h1FF;

    typedef enum logic {
        IDLE   = 1'b0,
        SEARCH = 1'b1
    } state_t;

    state_t              state;
    state_t              state_next;
    logic [15:0]         lfsr;
    logic                lfsr_fb;
    logic [5:0]          cx;
    logic [5:0]          cy;
    logic [9:0]          px;
    logic [8:0]          py;
    logic                cand_ok;
    logic                hit_any;
    logic [3:0]          hit_idx;
    logic                tgt_any;
    logic [3:0]          tgt_idx;
    logic                spawn;
    logic [NUM_FOOD-1:0] valid_next;

    // Fibonacci LFSR for x^16+x^14+x^13+x^11+1 in right-shifting form.
    assign lfsr_fb = lfsr[0] ^ lfsr[2] ^ lfsr[3] ^ lfsr[5];

    assign cx = lfsr[5:0];
    assign cy = lfsr[11:6];
    assign px = 10'(32'(cx) * CELL);
    // Truncation only matters for cy >= ROWS, which is rejected anyway.
    assign py = 9'(32'(cy) * CELL);

    always_comb begin
        hit_any    = 1'b0;
        hit_idx    = 4'd0;
        tgt_any    = 1'b0;
        tgt_idx    = 4'd0;
        cand_ok    = 1'b0;
        spawn      = 1'b0;
        valid_next = food_valid;
        state_next = state;

        // Descending scans so the lowest matching index wins.
        for (int i = NUM_FOOD - 1; i >= 0; i--) begin
            if (food_valid[i] && (foodx[i] == headx) && (foody[i] == heady)) begin
                hit_any = 1'b1;
                hit_idx = 4'(i);
            end
            if (!food_valid[i]) begin
                tgt_any = 1'b1;
                tgt_idx = 4'(i);
            end
        end

        cand_ok = (32'(cx) < COLS) && (32'(cy) < ROWS) &&
                  !((px == headx) && (py == heady));
        for (int i = 0; i < NUM_FOOD; i++) begin
            if (food_valid[i] && (foodx[i] == px) && (foody[i] == py)) begin
                cand_ok = 1'b0;
            end
        end

        // The target is an empty slot and the hit slot is a full one, so a
        // same-cycle hit and spawn always touch different slots.
        spawn = (state == SEARCH) && tgt_any && cand_ok;

        if (hit_any) begin
            valid_next[hit_idx] = 1'b0;
        end
        if (spawn) begin
            valid_next[tgt_idx] = 1'b1;
        end

        state_next = (&valid_next) ? IDLE : SEARCH;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= SEARCH;
            lfsr       <= SEED;
            food_valid <= '0;
            eaten      <= 1'b0;
            eaten_idx  <= 4'd0;
            all_placed <= 1'b0;
            for (int i = 0; i < NUM_FOOD; i++) begin
                foodx[i] <= PARK_X;
                foody[i] <= PARK_Y;
            end
        end else begin
            state      <= state_next;
            lfsr       <= {lfsr_fb, lfsr[15:1]};
            food_valid <= valid_next;
            all_placed <= &valid_next;
            eaten      <= hit_any;
            if (hit_any) begin
                eaten_idx <= hit_idx;
            end
            for (int i = 0; i < NUM_FOOD; i++) begin
                if (hit_any && (hit_idx == 4'(i))) begin
                    foodx[i] <= PARK_X;
                    foody[i] <= PARK_Y;
                end else if (spawn && (tgt_idx == 4'(i))) begin
                    foodx[i] <= px;
                    foody[i] <= py;
                end
            end
        end
    end

endmodule

// File: tb/tb_food_spawner.sv
// tb_food_spawner
//   Directed bench for food_spawner. A cycle-level reference model (LFSR,
//   candidate acceptance, hit servicing) predicts slot positions; scenario
//   tasks drive the head and compare DUT outputs against hand-derived and
//   model-derived values.
module tb_food_spawner;

    localparam int NF = 9;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [9:0]    headx = 10'd5;
    logic [8:0]    heady = 9'd5;
    logic [9:0]    foodx [NF];
    logic [8:0]    foody [NF];
    logic [NF-1:0] food_valid;
    logic          eaten;
    logic [3:0]    eaten_idx;
    logic          all_placed;

    // reference model state
    logic [15:0]   m_lfsr;
    logic [9:0]    m_x [NF];
    logic [8:0]    m_y [NF];
    logic [NF-1:0] m_v;

    int n_checks = 0;
    int n_pass   = 0;

    int         fill_t1 [NF];
    logic [9:0] fill_x1 [NF];
    logic [8:0] fill_y1 [NF];

    food_spawner #(
        .NUM_FOOD(NF),
        .CELL(10),
        .COLS(64),
        .ROWS(48),
        .SEED(16'hACE1)
    ) dut (
        .clk(clk),
        .reset(reset),
        .headx(headx),
        .heady(heady),
        .foodx(foodx),
        .foody(foody),
        .food_valid(food_valid),
        .eaten(eaten),
        .eaten_idx(eaten_idx),
        .all_placed(all_placed)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] lfsr_next(input logic [15:0] l);
        logic fb;
        fb = l[0] ^ l[2] ^ l[3] ^ l[5];
        return {fb, l[15:1]};
    endfunction

    function automatic logic [9:0] cand_px(input logic [15:0] l);
        int cx;
        cx = int'(l[5:0]);
        return 10'(cx * 10);
    endfunction

    function automatic logic [8:0] cand_py(input logic [15:0] l);
        int cy;
        cy = int'(l[11:6]);
        return 9'(cy * 10);
    endfunction

    function automatic bit cand_accept(input logic [15:0] l, input logic [9:0] hx,
                                       input logic [8:0] hy);
        int cx;
        int cy;
        cx = int'(l[5:0]);
        cy = int'(l[11:6]);
        if (cx >= 64 || cy >= 48) return 1'b0;
        if (cand_px(l) == hx && cand_py(l) == hy) return 1'b0;
        for (int i = 0; i < NF; i++) begin
            if (m_v[i] && m_x[i] == cand_px(l) && m_y[i] == cand_py(l)) return 1'b0;
        end
        return 1'b1;
    endfunction

    // Advance the model by one clock edge using the inputs currently driven.
    task automatic model_step();
        bit   hit;
        int   k;
        bit   have_tgt;
        int   j;
        bit   acc;
        if (reset) begin
            m_lfsr = 16'hACE1;
            m_v    = '0;
            for (int i = 0; i < NF; i++) begin
                m_x[i] = 10'h3FF;
                m_y[i] = 9'h1FF;
            end
            return;
        end
        hit = 1'b0;
        k = 0;
        for (int i = 0; i < NF; i++) begin
            if (!hit && m_v[i] && m_x[i] == headx && m_y[i] == heady) begin
                hit = 1'b1;
                k = i;
            end
        end
        have_tgt = 1'b0;
        j = 0;
        for (int i = 0; i < NF; i++) begin
            if (!have_tgt && !m_v[i]) begin
                have_tgt = 1'b1;
                j = i;
            end
        end
        acc = have_tgt && cand_accept(m_lfsr, headx, heady);
        if (hit) begin
            m_v[k] = 1'b0;
            m_x[k] = 10'h3FF;
            m_y[k] = 9'h1FF;
        end
        if (acc) begin
            m_v[j] = 1'b1;
            m_x[j] = cand_px(m_lfsr);
            m_y[j] = cand_py(m_lfsr);
        end
        m_lfsr = lfsr_next(m_lfsr);
    endtask

    task automatic cyc();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic settle(input int bound, output bit ok);
        ok = 1'b0;
        for (int c = 0; c < bound; c++) begin
            cyc();
            if (all_placed === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        bit parked;
        reset = 1'b1;
        headx = 10'd5;
        heady = 9'd5;
        cyc();
        cyc();
        n_checks++;
        if (food_valid !== '0) $display("FAIL reset_valid: got %h want 000", food_valid);
        else n_pass++;
        n_checks++;
        if (eaten !== 1'b0) $display("FAIL reset_eaten: got %b want 0", eaten);
        else n_pass++;
        n_checks++;
        if (eaten_idx !== 4'd0) $display("FAIL reset_eaten_idx: got %0d want 0", eaten_idx);
        else n_pass++;
        n_checks++;
        if (all_placed !== 1'b0) $display("FAIL reset_all_placed: got %b want 0", all_placed);
        else n_pass++;
        parked = 1'b1;
        for (int i = 0; i < NF; i++) begin
            if (foodx[i] !== 10'h3FF || foody[i] !== 9'h1FF) parked = 1'b0;
        end
        n_checks++;
        if (!parked) $display("FAIL reset_parked: got x0=%h y0=%h want 3ff/1ff", foodx[0], foody[0]);
        else n_pass++;
    endtask

    task automatic test_fill();
        bit ok;
        bit grid_ok;
        bit distinct;
        bit order_ok;
        ok = 1'b0;
        for (int i = 0; i < NF; i++) fill_t1[i] = -1;
        reset = 1'b0;
        for (int c = 1; c <= 300; c++) begin
            cyc();
            for (int i = 0; i < NF; i++) begin
                if (food_valid[i] === 1'b1 && fill_t1[i] < 0) fill_t1[i] = c;
            end
            if (all_placed === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
        n_checks++;
        if (!ok) $display("FAIL fill_timeout: all_placed=%b valid=%h want all placed within 300", all_placed, food_valid);
        else n_pass++;
        n_checks++;
        if (food_valid !== 9'h1FF) $display("FAIL fill_valid: got %h want 1ff", food_valid);
        else n_pass++;
        for (int i = 0; i < NF; i++) begin
            n_checks++;
            if (foodx[i] !== m_x[i] || foody[i] !== m_y[i])
                $display("FAIL fill_pos%0d: got (%0d,%0d) want (%0d,%0d)", i, foodx[i], foody[i], m_x[i], m_y[i]);
            else n_pass++;
            fill_x1[i] = foodx[i];
            fill_y1[i] = foody[i];
        end
        grid_ok = 1'b1;
        distinct = 1'b1;
        for (int i = 0; i < NF; i++) begin
            if ((foodx[i] % 10) != 0 || foodx[i] >= 640 || (foody[i] % 10) != 0 || foody[i] >= 480)
                grid_ok = 1'b0;
            for (int j = i + 1; j < NF; j++) begin
                if (foodx[i] == foodx[j] && foody[i] == foody[j]) distinct = 1'b0;
            end
        end
        n_checks++;
        if (!grid_ok) $display("FAIL fill_grid: got off-grid slot want all on grid");
        else n_pass++;
        n_checks++;
        if (!distinct) $display("FAIL fill_distinct: got duplicate cells want 9 distinct");
        else n_pass++;
        order_ok = 1'b1;
        for (int i = 1; i < NF; i++) begin
            if (fill_t1[i] <= fill_t1[i-1]) order_ok = 1'b0;
        end
        n_checks++;
        if (!order_ok) $display("FAIL fill_order: got t0=%0d t1=%0d want strictly increasing", fill_t1[0], fill_t1[1]);
        else n_pass++;
    endtask

    task automatic test_eat_slot3();
        bit ok;
        headx = m_x[3];
        heady = m_y[3];
        cyc();
        headx = 10'd5;
        heady = 9'd5;
        n_checks++;
        if (eaten !== 1'b1) $display("FAIL eat3_pulse: got %b want 1", eaten);
        else n_pass++;
        n_checks++;
        if (eaten_idx !== 4'd3) $display("FAIL eat3_idx: got %0d want 3", eaten_idx);
        else n_pass++;
        n_checks++;
        if (foodx[3] !== 10'h3FF || foody[3] !== 9'h1FF)
            $display("FAIL eat3_parked: got (%h,%h) want (3ff,1ff)", foodx[3], foody[3]);
        else n_pass++;
        n_checks++;
        if (food_valid[3] !== 1'b0) $display("FAIL eat3_valid: got %b want 0", food_valid[3]);
        else n_pass++;
        n_checks++;
        if (all_placed !== 1'b0) $display("FAIL eat3_all_placed: got %b want 0", all_placed);
        else n_pass++;
        cyc();
        n_checks++;
        if (eaten !== 1'b0) $display("FAIL eat3_single_pulse: got %b want 0", eaten);
        else n_pass++;
        settle(300, ok);
        n_checks++;
        if (!ok) $display("FAIL eat3_refill_timeout: got valid=%h want 1ff", food_valid);
        else n_pass++;
        n_checks++;
        if (foodx[3] !== m_x[3] || foody[3] !== m_y[3] || (foodx[3] % 10) != 0 || (foody[3] % 10) != 0)
            $display("FAIL eat3_refill_pos: got (%0d,%0d) want (%0d,%0d)", foodx[3], foody[3], m_x[3], m_y[3]);
        else n_pass++;
    endtask

    task automatic test_reject();
        logic [15:0] l;
        logic [9:0]  p1x;
        logic [8:0]  p1y;
        logic [9:0]  p2x;
        logic [8:0]  p2y;
        bit          found;
        bit          saw_eat;
        bit          ok;
        headx = m_x[0];
        heady = m_y[0];
        cyc();
        n_checks++;
        if (eaten !== 1'b1 || eaten_idx !== 4'd0)
            $display("FAIL rej_eat0: got eaten=%b idx=%0d want 1/0", eaten, eaten_idx);
        else n_pass++;
        // First candidate that would be accepted with the head out of the way.
        l = m_lfsr;
        for (int n = 0; n < 2000; n++) begin
            if (cand_accept(l, 10'd5, 9'd5)) break;
            l = lfsr_next(l);
        end
        p1x = cand_px(l);
        p1y = cand_py(l);
        // With the head parked on that cell, the next accepted one wins instead.
        l = lfsr_next(l);
        for (int n = 0; n < 2000; n++) begin
            if (cand_accept(l, p1x, p1y)) break;
            l = lfsr_next(l);
        end
        p2x = cand_px(l);
        p2y = cand_py(l);
        headx = p1x;
        heady = p1y;
        found = 1'b0;
        saw_eat = 1'b0;
        for (int c = 0; c < 2000; c++) begin
            cyc();
            if (eaten === 1'b1) saw_eat = 1'b1;
            if (food_valid[0] === 1'b1) begin
                found = 1'b1;
                break;
            end
        end
        n_checks++;
        if (!found) $display("FAIL rej_refill_timeout: got valid=%h want slot0 set", food_valid);
        else n_pass++;
        n_checks++;
        if (saw_eat) $display("FAIL rej_no_eat: got eaten=1 want 0");
        else n_pass++;
        n_checks++;
        if (foodx[0] !== p2x || foody[0] !== p2y)
            $display("FAIL rej_pos: got (%0d,%0d) want (%0d,%0d) head (%0d,%0d)", foodx[0], foody[0], p2x, p2y, p1x, p1y);
        else n_pass++;
        headx = 10'd5;
        heady = 9'd5;
        settle(300, ok);
        n_checks++;
        if (!ok) $display("FAIL rej_settle: got all_placed=%b want 1", all_placed);
        else n_pass++;
    endtask

    task automatic test_back_to_back();
        int t2;
        int t5;
        bit ok;
        headx = m_x[2];
        heady = m_y[2];
        cyc();
        n_checks++;
        if (eaten !== 1'b1 || eaten_idx !== 4'd2 || food_valid[2] !== 1'b0)
            $display("FAIL b2b_first: got eaten=%b idx=%0d v2=%b want 1/2/0", eaten, eaten_idx, food_valid[2]);
        else n_pass++;
        headx = m_x[5];
        heady = m_y[5];
        cyc();
        n_checks++;
        if (eaten !== 1'b1 || eaten_idx !== 4'd5 || food_valid[5] !== 1'b0)
            $display("FAIL b2b_second: got eaten=%b idx=%0d v5=%b want 1/5/0", eaten, eaten_idx, food_valid[5]);
        else n_pass++;
        t2 = (food_valid[2] === 1'b1) ? 0 : -1;
        t5 = -1;
        headx = 10'd5;
        heady = 9'd5;
        ok = 1'b0;
        for (int c = 1; c <= 300; c++) begin
            cyc();
            if (food_valid[2] === 1'b1 && t2 < 0) t2 = c;
            if (food_valid[5] === 1'b1 && t5 < 0) t5 = c;
            if (all_placed === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
        n_checks++;
        if (!ok) $display("FAIL b2b_refill_timeout: got valid=%h want 1ff", food_valid);
        else n_pass++;
        n_checks++;
        if (t2 < 0 || t5 < 0 || t2 >= t5) $display("FAIL b2b_order: got t2=%0d t5=%0d want t2<t5", t2, t5);
        else n_pass++;
        n_checks++;
        if (foodx[2] !== m_x[2] || foody[2] !== m_y[2] || foodx[5] !== m_x[5] || foody[5] !== m_y[5])
            $display("FAIL b2b_pos: got (%0d,%0d)(%0d,%0d) want (%0d,%0d)(%0d,%0d)",
                     foodx[2], foody[2], foodx[5], foody[5], m_x[2], m_y[2], m_x[5], m_y[5]);
        else n_pass++;
    endtask

    task automatic test_reset_mid();
        bit reached;
        bit parked;
        bit ok;
        int t2 [NF];
        reset = 1'b1;
        cyc();
        reset = 1'b0;
        reached = 1'b0;
        for (int c = 0; c < 300; c++) begin
            cyc();
            if ($countones(food_valid) == 4) begin
                reached = 1'b1;
                break;
            end
        end
        n_checks++;
        if (!reached) $display("FAIL mid_reach4: got valid=%h want 4 slots placed", food_valid);
        else n_pass++;
        // Head sits on a placed slot during the reset cycle: no pulse may follow.
        headx = m_x[0];
        heady = m_y[0];
        reset = 1'b1;
        cyc();
        headx = 10'd5;
        heady = 9'd5;
        parked = 1'b1;
        for (int i = 0; i < NF; i++) begin
            if (foodx[i] !== 10'h3FF || foody[i] !== 9'h1FF) parked = 1'b0;
        end
        n_checks++;
        if (food_valid !== '0 || !parked)
            $display("FAIL mid_reset_clear: got valid=%h x0=%h want 000/3ff", food_valid, foodx[0]);
        else n_pass++;
        n_checks++;
        if (eaten !== 1'b0 || all_placed !== 1'b0)
            $display("FAIL mid_reset_flags: got eaten=%b all=%b want 0/0", eaten, all_placed);
        else n_pass++;
        cyc();
        reset = 1'b0;
        for (int i = 0; i < NF; i++) t2[i] = -1;
        ok = 1'b0;
        for (int c = 1; c <= 300; c++) begin
            cyc();
            for (int i = 0; i < NF; i++) begin
                if (food_valid[i] === 1'b1 && t2[i] < 0) t2[i] = c;
            end
            if (all_placed === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
        n_checks++;
        if (!ok) $display("FAIL mid_refill_timeout: got valid=%h want 1ff", food_valid);
        else n_pass++;
        for (int i = 0; i < NF; i++) begin
            n_checks++;
            if (t2[i] != fill_t1[i] || foodx[i] !== fill_x1[i] || foody[i] !== fill_y1[i])
                $display("FAIL mid_replay%0d: got t=%0d (%0d,%0d) want t=%0d (%0d,%0d)",
                         i, t2[i], foodx[i], foody[i], fill_t1[i], fill_x1[i], fill_y1[i]);
            else n_pass++;
        end
    endtask

    task automatic test_hold();
        int pulses;
        bit ok;
        pulses = 0;
        headx = m_x[7];
        heady = m_y[7];
        for (int c = 0; c < 3; c++) begin
            cyc();
            if (eaten === 1'b1) pulses++;
            if (c == 0) begin
                n_checks++;
                if (eaten !== 1'b1 || eaten_idx !== 4'd7)
                    $display("FAIL hold_first: got eaten=%b idx=%0d want 1/7", eaten, eaten_idx);
                else n_pass++;
            end
        end
        headx = 10'd5;
        heady = 9'd5;
        cyc();
        if (eaten === 1'b1) pulses++;
        n_checks++;
        if (pulses != 1) $display("FAIL hold_pulses: got %0d want 1", pulses);
        else n_pass++;
        settle(300, ok);
        n_checks++;
        if (!ok || foodx[7] !== m_x[7] || foody[7] !== m_y[7])
            $display("FAIL hold_refill: got (%0d,%0d) want (%0d,%0d)", foodx[7], foody[7], m_x[7], m_y[7]);
        else n_pass++;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_fill();
        test_eat_slot3();
        test_reject();
        test_back_to_back();
        test_reset_mid();
        test_hold();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
